// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline register: captures the instruction leaving the memory stage,
// selects its writeback value, and sequences stall/flush, sticky halt, dump pulse and retire count.
module mem_wb_pipe #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              inValid,
    input  logic [DATA_W-1:0] memOut,
    input  logic [DATA_W-1:0] aluOut,
    input  logic [DATA_W-1:0] pcPlus2,
    input  logic [DATA_W-1:0] imm,
    input  logic [1:0]        wbSel,
    input  logic              regWrite,
    input  logic [REG_W-1:0]  writeReg,
    input  logic              halt,
    output logic              wbValid,
    output logic              wbRegWrite,
    output logic [REG_W-1:0]  wbWriteReg,
    output logic [DATA_W-1:0] wbData,
    output logic              wbHalt,
    output logic              createDump,
    output logic [15:0]       retireCount
);

    typedef enum logic [1:0] {
        SEL_ALU = 2'b00,
        SEL_MEM = 2'b01,
        SEL_PC2 = 2'b10,
        SEL_IMM = 2'b11
    } wb_sel_e;

    logic [DATA_W-1:0] wb_mux;

    // NOTE: the default assignment ahead of the case keeps this purely combinational (no latch).
    always_comb begin
        wb_mux = aluOut;
        case (wb_sel_e'(wbSel))
            SEL_ALU: wb_mux = aluOut;
            SEL_MEM: wb_mux = memOut;
            SEL_PC2: wb_mux = pcPlus2;
            SEL_IMM: wb_mux = imm;
            default: wb_mux = aluOut;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wbValid     <= 1'b0;
            wbRegWrite  <= 1'b0;
            wbWriteReg  <= '0;
            wbData      <= '0;
            wbHalt      <= 1'b0;
            createDump  <= 1'b0;
            retireCount <= '0;
        end else if (flush) begin
            // Bubble inserted; halt state and retire count survive a flush.
            wbValid    <= 1'b0;
            wbRegWrite <= 1'b0;
            wbWriteReg <= '0;
            wbData     <= '0;
            createDump <= 1'b0;
        end else if (stall) begin
            createDump <= 1'b0;
        end else if (wbHalt) begin
            // Halted: the entry freezes and no further writes reach the register file.
            wbValid    <= 1'b0;
            wbRegWrite <= 1'b0;
            createDump <= 1'b0;
        end else begin
            wbValid    <= inValid;
            wbRegWrite <= regWrite & inValid;
            wbWriteReg <= writeReg;
            wbData     <= wb_mux;
            createDump <= inValid & halt;
            if (inValid) begin
                retireCount <= retireCount + 16'd1;
                if (halt) wbHalt <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Scoreboard bench for mem_wb_pipe: the driver predicts each edge's outcome from the
// behavioural rules and queues it; a negedge monitor compares the DUT against the queue.
module tb_mem_wb_pipe;

    logic        clk = 1'b0;
    logic        rst, stall, flush, inValid, regWrite, halt;
    logic [15:0] memOut, aluOut, pcPlus2, imm;
    logic [1:0]  wbSel;
    logic [2:0]  writeReg;
    logic        wbValid, wbRegWrite, wbHalt, createDump;
    logic [2:0]  wbWriteReg;
    logic [15:0] wbData, retireCount;

    typedef struct {
        logic        valid;
        logic        regw;
        logic [2:0]  wreg;
        logic [15:0] data;
        logic        data_care;
        logic        halted;
        logic        dump;
        logic [15:0] count;
    } exp_t;

    exp_t model;
    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    mem_wb_pipe #(.DATA_W(16), .REG_W(3)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .inValid(inValid),
        .memOut(memOut), .aluOut(aluOut), .pcPlus2(pcPlus2), .imm(imm),
        .wbSel(wbSel), .regWrite(regWrite), .writeReg(writeReg), .halt(halt),
        .wbValid(wbValid), .wbRegWrite(wbRegWrite), .wbWriteReg(wbWriteReg),
        .wbData(wbData), .wbHalt(wbHalt), .createDump(createDump),
        .retireCount(retireCount)
    );

    task automatic check(input string name, input logic [15:0] actual, input logic [15:0] required);
        n_checks++;
        if (actual === required) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, required, $time);
    endtask

    // Outcome of one edge, written as the pipeline's rules in priority order.
    function automatic exp_t predict(input exp_t cur);
        exp_t  n = cur;
        logic [15:0] picks [4];
        picks[0] = aluOut; picks[1] = memOut; picks[2] = pcPlus2; picks[3] = imm;
        if (!rst) begin
            n = '{valid: 0, regw: 0, wreg: 0, data: 0, data_care: 1, halted: 0, dump: 0, count: 0};
        end else if (flush) begin
            n.valid = 0; n.regw = 0; n.wreg = 0; n.data = 0; n.data_care = 1; n.dump = 0;
        end else if (stall) begin
            n.dump = 0;
        end else if (cur.halted) begin
            n.valid = 0; n.regw = 0; n.dump = 0;
        end else begin
            n.valid     = inValid;
            n.regw      = inValid && regWrite;
            n.wreg      = writeReg;
            n.data      = picks[wbSel];
            n.data_care = inValid;
            n.dump      = inValid && halt;
            if (inValid) begin
                n.count  = 16'((32'(cur.count) + 1) % 65536);
                n.halted = halt;
            end
        end
        return n;
    endfunction

    task automatic tick();
        model = predict(model);
        sb.push_back(model);
        @(posedge clk);
        #1;
    endtask

    task automatic rand_inputs();
        memOut   = 16'($urandom); aluOut = 16'($urandom);
        pcPlus2  = 16'($urandom); imm    = 16'($urandom);
        wbSel    = 2'($urandom);  writeReg = 3'($urandom);
        regWrite = 1'($urandom);  inValid  = 1'($urandom);
        halt     = 1'b0;
    endtask

    task automatic plain_load(input logic [1:0] sel, input logic [15:0] alu);
        rand_inputs();
        rst = 1; stall = 0; flush = 0; inValid = 1; wbSel = sel; aluOut = alu;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("wbValid",     16'(wbValid),     16'(e.valid));
            check("wbRegWrite",  16'(wbRegWrite),  16'(e.regw));
            check("wbHalt",      16'(wbHalt),      16'(e.halted));
            check("createDump",  16'(createDump),  16'(e.dump));
            check("retireCount", retireCount,      e.count);
            if (e.data_care) begin
                check("wbData",     wbData,           e.data);
                check("wbWriteReg", 16'(wbWriteReg),  16'(e.wreg));
            end
        end
    end

    initial begin
        model = '{valid: 0, regw: 0, wreg: 0, data: 0, data_care: 1, halted: 0, dump: 0, count: 0};
        rand_inputs();
        rst = 0; stall = 0; flush = 0;

        // Reset with random inputs, then the first load.
        repeat (2) begin rand_inputs(); stall = 1'($urandom); flush = 1'($urandom); tick(); end
        rand_inputs();
        rst = 1; stall = 0; flush = 0;
        inValid = 1; wbSel = 2'b01; memOut = 16'hBEEF; writeReg = 3'd5; regWrite = 1;
        tick();

        // Writeback select sweep.
        for (int s = 0; s < 4; s++) begin
            plain_load(2'(s), 16'h1111);
            memOut = 16'h2222; pcPlus2 = 16'h3333; imm = 16'h4444;
            tick();
        end

        // Stall holds, flush beats stall.
        plain_load(2'b00, 16'hAAAA); tick();
        repeat (3) begin plain_load(2'b00, 16'h5555); stall = 1; tick(); end
        plain_load(2'b00, 16'h5555); stall = 1; flush = 1; tick();

        // Halt: sticky, freezes loads, cleared only by reset.
        plain_load(2'b00, 16'h0123); halt = 1; regWrite = 0; tick();
        repeat (5) begin plain_load(2'b01, 16'h7777); tick(); end
        rand_inputs(); rst = 0; tick();

        // Halt followed by stall: dump pulse must not stretch.
        plain_load(2'b00, 16'h0042); tick();
        plain_load(2'b10, 16'h0043); halt = 1; regWrite = 1; tick();
        repeat (2) begin plain_load(2'b00, 16'h0044); stall = 1; tick(); end
        plain_load(2'b00, 16'h0045); tick();

        // Reset on the dump cycle leaves no residue.
        rand_inputs(); rst = 0; tick();
        plain_load(2'b00, 16'h0046); halt = 1; tick();
        rand_inputs(); rst = 0; tick();

        // Counter wrap after 0x10000 valid loads; bubbles don't count.
        for (int i = 0; i < 65536; i++) begin plain_load(2'($urandom), 16'($urandom)); tick(); end
        repeat (3) begin plain_load(2'b00, 16'h0); inValid = 0; tick(); end

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            rst   = ($urandom_range(0, 59) != 0);
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 9) == 0);
            halt  = ($urandom_range(0, 39) == 0);
            tick();
        end

        @(negedge clk);
        #1;
        check("scoreboard_drained", 16'(sb.size()), 16'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
